// File: rtl/irq_sequencer.sv
// -----------------------------------------------------------------------------
// irq_sequencer
// CPU-side interrupt entry/return sequencer. Waits for an instruction boundary,
// saves the return PC, acknowledges the controller and redirects fetch to the
// ISR vector; on MRET it redirects back to mepc and restores the interrupt
// enable. One ISR in flight at a time (no nesting).
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   irq_i             level interrupt request from the interrupt controller
//   isr_addr_i        ISR vector of the currently selected source
//   boundary_i        core at an instruction boundary, pc_next_i valid
//   pc_next_i         PC of the next instruction to execute
//   mret_i            return-from-interrupt retired (1-cycle pulse)
//   mie_we_i          CSR write strobe for the global interrupt enable
//   mie_wdata_i       CSR write data for the global interrupt enable
//   iack_o            interrupt acknowledge, one cycle per taken interrupt
//   hold_o            stall fetch/issue while the sequencer owns the PC
//   redirect_o        1-cycle pulse: load redirect_pc_o into the PC
//   redirect_pc_o     redirect target (ISR vector or mepc), holds when idle
//   mepc_o            saved return PC
//   mie_o             global interrupt enable
//   in_isr_o          ISR in progress
// -----------------------------------------------------------------------------
module irq_sequencer #(
    parameter int unsigned ADDR_W    = 32,
    parameter bit          MIE_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              irq_i,
    input  logic [ADDR_W-1:0] isr_addr_i,
    input  logic              boundary_i,
    input  logic [ADDR_W-1:0] pc_next_i,
    input  logic              mret_i,
    input  logic              mie_we_i,
    input  logic              mie_wdata_i,
    output logic              iack_o,
    output logic              hold_o,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic [ADDR_W-1:0] mepc_o,
    output logic              mie_o,
    output logic              in_isr_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PEND   = 3'd1,
        ST_ACK    = 3'd2,
        ST_VECTOR = 3'd3,
        ST_RETURN = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              mie_q, mie_d;
    logic              mpie_q, mpie_d;
    logic              in_isr_q, in_isr_d;
    logic [ADDR_W-1:0] mepc_q, mepc_d;
    logic [ADDR_W-1:0] vector_q, vector_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic              iack_q, iack_d;
    logic              hold_q, hold_d;
    logic              redirect_q, redirect_d;
    logic              mie_eff;

    // State and architectural registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            mie_q         <= MIE_RESET;
            mpie_q        <= 1'b0;
            in_isr_q      <= 1'b0;
            mepc_q        <= '0;
            vector_q      <= '0;
            redirect_pc_q <= '0;
            iack_q        <= 1'b0;
            hold_q        <= 1'b0;
            redirect_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            mie_q         <= mie_d;
            mpie_q        <= mpie_d;
            in_isr_q      <= in_isr_d;
            mepc_q        <= mepc_d;
            vector_q      <= vector_d;
            redirect_pc_q <= redirect_pc_d;
            iack_q        <= iack_d;
            hold_q        <= hold_d;
            redirect_q    <= redirect_d;
        end
    end

    // Next-state, register updates and output decode
    always_comb begin
        state_d       = state_q;
        mie_d         = mie_q;
        mpie_d        = mpie_q;
        in_isr_d      = in_isr_q;
        mepc_d        = mepc_q;
        vector_d      = vector_q;
        redirect_pc_d = redirect_pc_q;
        // CSR write seen in the same cycle, so a clear aborts a pending entry
        mie_eff       = mie_we_i ? mie_wdata_i : mie_q;

        unique case (state_q)
            ST_IDLE: begin
                mie_d = mie_eff;
                if (mret_i && in_isr_q) begin
                    state_d       = ST_RETURN;
                    redirect_pc_d = mepc_q;
                end else if (irq_i && mie_q && !in_isr_q) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                mie_d = mie_eff;
                if (!irq_i || !mie_eff) begin
                    state_d = ST_IDLE;
                end else if (boundary_i) begin
                    // Vector frozen here; later isr_addr changes are ignored
                    mepc_d   = pc_next_i;
                    vector_d = isr_addr_i;
                    state_d  = ST_ACK;
                end
            end
            ST_ACK: begin
                mpie_d        = mie_q;
                mie_d         = 1'b0;
                in_isr_d      = 1'b1;
                redirect_pc_d = vector_q;
                state_d       = ST_VECTOR;
            end
            ST_VECTOR: begin
                state_d = ST_IDLE;
            end
            ST_RETURN: begin
                mie_d    = mpie_q;
                mpie_d   = 1'b1;
                in_isr_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs registered from the next state so they align with state_q
        iack_d     = (state_d == ST_ACK);
        hold_d     = (state_d != ST_IDLE);
        redirect_d = (state_d == ST_VECTOR) || (state_d == ST_RETURN);
    end

    assign iack_o        = iack_q;
    assign hold_o        = hold_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign mepc_o        = mepc_q;
    assign mie_o         = mie_q;
    assign in_isr_o      = in_isr_q;

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- CPU-side interrupt entry/return sequencer, directly downstream of the 4-source interrupt controller.
- Consumes the controller's IRQ and isr_addr; returns a single-cycle IACK.
- Holds the core at an instruction boundary, saves the return PC, and redirects fetch to the ISR. Restores PC and interrupt enable on MRET.
- Non-nesting: one ISR in flight at a time.

Parameters:
- ADDR_W, 32, width of PC and ISR address.
- MIE_RESET, 0, value of the global interrupt enable after reset.

Ports:
- clk  input  1  system clock, all flops rising-edge
- rst_n  input  1  asynchronous active-low reset
- irq  input  1  level interrupt request from the interrupt controller
- isr_addr  input  ADDR_W  ISR vector for the currently selected source
- boundary  input  1  core is at an instruction boundary; pc_next is valid this cycle
- pc_next  input  ADDR_W  PC of the next instruction to execute
- mret  input  1  return-from-interrupt instruction retired (1-cycle pulse)
- mie_we  input  1  CSR write strobe for the global interrupt enable
- mie_wdata  input  1  CSR write data for the global interrupt enable
- iack  output  1  interrupt acknowledge, exactly one cycle per taken interrupt
- hold  output  1  stall fetch/issue while the sequencer owns the PC
- redirect  output  1  1-cycle pulse: load redirect_pc into the PC
- redirect_pc  output  ADDR_W  redirect target (ISR vector or mepc)
- mepc  output  ADDR_W  saved return PC
- mie  output  1  global interrupt enable
- in_isr  output  1  ISR in progress

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, mie=MIE_RESET, mpie=0, in_isr=0, mepc=0, vector=0.
  - iack=0, hold=0, redirect=0, redirect_pc=0.
- Outputs are registered or decoded from state only. No combinational path from irq to iack.
- FSM states: IDLE, PEND, ACK, VECTOR, RETURN.
- IDLE:
  - mret && in_isr → RETURN. mret takes priority over irq in the same cycle.
  - Else irq && mie && !in_isr → PEND.
  - mret && !in_isr: ignored, no state change.
- PEND: hold=1.
  - If !irq or !mie (either deasserted, incl. a same-cycle mie_we clear) → IDLE, hold drops next cycle, no iack.
  - Else if boundary: mepc<=pc_next, vector<=isr_addr → ACK.
  - Else stay in PEND.
- ACK: hold=1, iack=1 for this cycle only. mpie<=mie, mie<=0, in_isr<=1 → VECTOR.
- VECTOR: hold=1, redirect=1, redirect_pc=vector → IDLE.
- RETURN: hold=1, redirect=1, redirect_pc=mepc. mie<=mpie, mpie<=1, in_isr<=0 → IDLE.
- Vector is latched in the same cycle the boundary is accepted. Later isr_addr changes (e.g. a higher-priority source arriving) do not alter the taken vector.
- mie_we:
  - Updates mie in IDLE and PEND.
  - Ignored in ACK, VECTOR, RETURN; the sequencer's own update wins.
  - A write setting mie inside an ISR (in_isr=1) does not cause nesting; the in_isr gate holds.
- Latency, best case (irq, mie, boundary all high, cycle 0 in IDLE):
  - PEND on cycle 1.
  - iack on cycle 2.
  - redirect on cycle 3.
  - hold high on cycles 1–3.
- Return latency: mret in IDLE on cycle 0 → redirect on cycle 1, in_isr=0 and mie restored from cycle 2.
- Reset mid-sequence: any state → IDLE immediately. No iack or redirect is emitted after reset deassertion until a new request arrives.
- redirect_pc holds its last value when redirect=0.

Test Plan:
- Basic entry: mie=1; irq=1 with isr_addr=0x0000_0100, pc_next=0x0000_0040, boundary=1 → iack on cycle 2, redirect=1 with redirect_pc=0x100 on cycle 3, mepc=0x40, mie=0, in_isr=1.
- Boundary wait: boundary held 0 for 5 cycles after PEND → hold=1 throughout, iack exactly 1 cycle after boundary rises, mepc = pc_next at that boundary.
- Return: in ISR with mepc=0x40, pulse mret → redirect_pc=0x40 next cycle, mie=1, in_isr=0. A still-asserted irq is taken again starting the following cycle.
- Masking/abort: mie=0 with irq=1 → no hold, no iack. Set mie=1 then clear it via mie_we while in PEND with boundary=0 → back to IDLE, zero iack pulses.
- Simultaneous/no-nest: irq=1 during ISR with mie set by CSR write → no second iack until after mret. Drop irq in PEND → no iack, hold released.
- Async reset: assert rst_n=0 while in ACK → iack=0 and hold=0 immediately, all registers at reset values. Release with irq=0 → stays IDLE.
